lsu_mm_sched: RTL and testbench

Matmul load/feed scheduler for the LSU matrix path. It accepts one matmul command at a time and streams the A-operand rows, then the B-operand rows, out of the shared 128-bit LSU RAM through its single read port. It routes the returned lines to the A or B operand buffer as allocation writes, then sequences the MXU feed window. A secondary LSU requester shares the RAM read port and is granted only on cycles the scheduler does not use it.

---
 rtl/lsu_mm_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_lsu_mm_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mm_sched.sv
// -----------------------------------------------------------------------------
// lsu_mm_sched -- matmul load/feed scheduler for the LSU matrix path.
//
// Takes one matmul command at a time. Streams the A-operand rows, then the
// B-operand rows, out of the shared 128-bit LSU RAM through its single read
// port. Routes each returned line into the A or B operand buffer as an
// allocation write, then runs the MXU feed window (R+C-1 steps) and pulses
// done. A secondary requester shares the read port and is granted on every
// cycle the scheduler itself is not reading (i.e. outside LOAD_A/LOAD_B).
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   i_lsu_mm_sched_cmd_*             command handshake and operands
//   o_lsu_mm_sched_cmd_rdy           high only while idle
//   i_lsu_mm_sched_ext_req/addr      secondary read request, line address
//   o_lsu_mm_sched_ext_gnt           secondary grant (combinational)
//   o_lsu_mm_sched_ext_rdata_vld     secondary data valid, 1 cycle after grant
//   o_lsu_mm_sched_ram_read_vld/addr RAM read strobe and line address
//   i_lsu_mm_sched_ram_rdata         RAM read data (RD_LAT = 1)
//   o_lsu_mm_sched_a/b_alloc_vld     operand buffer write strobes
//   o_lsu_mm_sched_alloc_addr/data   buffer entry index, line data
//   o_lsu_mm_sched_mxu_vld/step      MXU feed window and step index
//   o_lsu_mm_sched_done/err          completion pulse, illegal-length flag
// -----------------------------------------------------------------------------
module lsu_mm_sched #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_lsu_mm_sched_cmd_vld,
   output logic         o_lsu_mm_sched_cmd_rdy,
   input  logic [11:0]  i_lsu_mm_sched_cmd_a_addr,
   input  logic [11:0]  i_lsu_mm_sched_cmd_b_addr,
   input  logic [3:0]   i_lsu_mm_sched_cmd_row_len,
   input  logic [3:0]   i_lsu_mm_sched_cmd_col_len,
   input  logic         i_lsu_mm_sched_ext_req,
   input  logic [7:0]   i_lsu_mm_sched_ext_addr,
   output logic         o_lsu_mm_sched_ext_gnt,
   output logic         o_lsu_mm_sched_ext_rdata_vld,
   output logic         o_lsu_mm_sched_ram_read_vld,
   output logic [7:0]   o_lsu_mm_sched_ram_read_addr,
   input  logic [127:0] i_lsu_mm_sched_ram_rdata,
   output logic         o_lsu_mm_sched_a_alloc_vld,
   output logic         o_lsu_mm_sched_b_alloc_vld,
   output logic [3:0]   o_lsu_mm_sched_alloc_addr,
   output logic [127:0] o_lsu_mm_sched_alloc_data,
   output logic         o_lsu_mm_sched_mxu_vld,
   output logic [4:0]   o_lsu_mm_sched_mxu_step,
   output logic         o_lsu_mm_sched_done,
   output logic         o_lsu_mm_sched_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_DRAIN,
      S_FEED,
      S_DONE
   } state_t;

   // DRAIN waits out the RAM pipe so the last B line has returned before FEED.
   localparam logic [4:0] DRAIN_LAST = 5'(RD_LAT - 1);

   state_t       r_state;
   logic [4:0]   r_cnt;        // row index in loads, drain count, feed step
   logic [7:0]   r_a_base;
   logic [7:0]   r_b_base;
   logic [3:0]   r_row_len;
   logic [3:0]   r_col_len;
   logic         r_cmd_rdy;
   logic         r_mxu_vld;
   logic [4:0]   r_mxu_step;
   logic         r_done;
   logic         r_err;

   // Tag pipe: one stage matching the RAM latency, marks what each return is.
   logic         r_tag_vld;
   logic         r_tag_is_b;
   logic [3:0]   r_tag_idx;
   logic         r_ext_vld;

   logic         w_loading;
   logic [7:0]   w_sch_rd_addr;
   logic         w_ext_gnt;
   logic [4:0]   w_a_last;
   logic [4:0]   w_b_last;
   logic [4:0]   w_feed_last;
   logic         w_unused;

   assign w_loading     = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
   // 8-bit sum: line addresses wrap modulo 256.
   assign w_sch_rd_addr = ((r_state == S_LOAD_B) ? r_b_base : r_a_base) + {3'b000, r_cnt};
   assign w_ext_gnt     = i_lsu_mm_sched_ext_req & ~w_loading;

   assign w_a_last    = {1'b0, r_row_len} - 5'd1;
   assign w_b_last    = {1'b0, r_col_len} - 5'd1;
   // Feed length N = R + C - 1, so the last step is R + C - 2 (0..28).
   assign w_feed_last = {1'b0, r_row_len} + {1'b0, r_col_len} - 5'd2;

   // Byte-offset bits inside a 16-byte line carry no information here.
   assign w_unused = ^{i_lsu_mm_sched_cmd_a_addr[3:0], i_lsu_mm_sched_cmd_b_addr[3:0]};

   // Control FSM; all handshake/feed outputs are registered here.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch and
      // the sensitivity list carries only the clock.
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_a_base   <= '0;
         r_b_base   <= '0;
         r_row_len  <= '0;
         r_col_len  <= '0;
         r_cmd_rdy  <= 1'b1;
         r_mxu_vld  <= 1'b0;
         r_mxu_step <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments everywhere in clocked logic so every
         // register sees the pre-edge value of every other register.
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_lsu_mm_sched_cmd_vld) begin
                  r_a_base  <= i_lsu_mm_sched_cmd_a_addr[11:4];
                  r_b_base  <= i_lsu_mm_sched_cmd_b_addr[11:4];
                  r_row_len <= i_lsu_mm_sched_cmd_row_len;
                  r_col_len <= i_lsu_mm_sched_cmd_col_len;
                  r_cmd_rdy <= 1'b0;
                  r_cnt     <= '0;
                  if ((i_lsu_mm_sched_cmd_row_len == 4'd0) ||
                      (i_lsu_mm_sched_cmd_col_len == 4'd0)) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_LOAD_A;
                  end
               end
            end
            S_LOAD_A: begin
               if (r_cnt == w_a_last) begin
                  r_state <= S_LOAD_B;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            S_LOAD_B: begin
               if (r_cnt == w_b_last) begin
                  r_state <= S_DRAIN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            S_DRAIN: begin
               if (r_cnt == DRAIN_LAST) begin
                  r_state    <= S_FEED;
                  r_cnt      <= '0;
                  r_mxu_vld  <= 1'b1;
                  r_mxu_step <= '0;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            S_FEED: begin
               if (r_cnt == w_feed_last) begin
                  r_state    <= S_DONE;
                  r_cnt      <= '0;
                  r_mxu_vld  <= 1'b0;
                  r_mxu_step <= '0;
                  r_done     <= 1'b1;
               end else begin
                  r_cnt      <= r_cnt + 5'd1;
                  r_mxu_step <= r_cnt + 5'd1;
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               r_cmd_rdy <= 1'b1;
            end
            default: begin
               r_state   <= S_IDLE;
               r_cmd_rdy <= 1'b1;
            end
         endcase
      end
   end

   // Return tagging: scheduler reads carry {is_b, idx}; ext reads carry none.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tag_vld  <= 1'b0;
         r_tag_is_b <= 1'b0;
         r_tag_idx  <= '0;
         r_ext_vld  <= 1'b0;
      end else begin
         r_tag_vld  <= w_loading;
         r_tag_is_b <= w_loading && (r_state == S_LOAD_B);
         r_tag_idx  <= w_loading ? r_cnt[3:0] : 4'd0;
         r_ext_vld  <= w_ext_gnt;
      end
   end

   assign o_lsu_mm_sched_cmd_rdy       = r_cmd_rdy;
   assign o_lsu_mm_sched_ext_gnt       = w_ext_gnt;
   assign o_lsu_mm_sched_ext_rdata_vld = r_ext_vld;
   assign o_lsu_mm_sched_ram_read_vld  = w_loading | w_ext_gnt;
   assign o_lsu_mm_sched_ram_read_addr = w_loading ? w_sch_rd_addr : i_lsu_mm_sched_ext_addr;
   assign o_lsu_mm_sched_a_alloc_vld   = r_tag_vld & ~r_tag_is_b;
   assign o_lsu_mm_sched_b_alloc_vld   = r_tag_vld &  r_tag_is_b;
   assign o_lsu_mm_sched_alloc_addr    = r_tag_idx;
   assign o_lsu_mm_sched_alloc_data    = i_lsu_mm_sched_ram_rdata;
   assign o_lsu_mm_sched_mxu_vld       = r_mxu_vld;
   assign o_lsu_mm_sched_mxu_step      = r_mxu_step;
   assign o_lsu_mm_sched_done          = r_done;
   assign o_lsu_mm_sched_err           = r_err;

endmodule

// File: tb/tb_lsu_mm_sched.sv
// -----------------------------------------------------------------------------
// tb_lsu_mm_sched -- directed self-checking bench for lsu_mm_sched.
// Cycle numbering: the accept edge is T; "cycle T+i" is the period that
// follows edge T+i-1 and is sampled at its falling edge.
// -----------------------------------------------------------------------------
module tb_lsu_mm_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_vld = 1'b0;
   logic         cmd_rdy;
   logic [11:0]  cmd_a_addr = '0;
   logic [11:0]  cmd_b_addr = '0;
   logic [3:0]   cmd_row_len = '0;
   logic [3:0]   cmd_col_len = '0;
   logic         ext_req = 1'b0;
   logic [7:0]   ext_addr = '0;
   logic         ext_gnt;
   logic         ext_rdata_vld;
   logic         ram_read_vld;
   logic [7:0]   ram_read_addr;
   logic [127:0] ram_rdata = '0;
   logic         a_alloc_vld;
   logic         b_alloc_vld;
   logic [3:0]   alloc_addr;
   logic [127:0] alloc_data;
   logic         mxu_vld;
   logic [4:0]   mxu_step;
   logic         done;
   logic         err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lsu_mm_sched #(.RD_LAT(1)) dut (
      .clk                          (clk),
      .rst_n                        (rst_n),
      .i_lsu_mm_sched_cmd_vld       (cmd_vld),
      .o_lsu_mm_sched_cmd_rdy       (cmd_rdy),
      .i_lsu_mm_sched_cmd_a_addr    (cmd_a_addr),
      .i_lsu_mm_sched_cmd_b_addr    (cmd_b_addr),
      .i_lsu_mm_sched_cmd_row_len   (cmd_row_len),
      .i_lsu_mm_sched_cmd_col_len   (cmd_col_len),
      .i_lsu_mm_sched_ext_req       (ext_req),
      .i_lsu_mm_sched_ext_addr      (ext_addr),
      .o_lsu_mm_sched_ext_gnt       (ext_gnt),
      .o_lsu_mm_sched_ext_rdata_vld (ext_rdata_vld),
      .o_lsu_mm_sched_ram_read_vld  (ram_read_vld),
      .o_lsu_mm_sched_ram_read_addr (ram_read_addr),
      .i_lsu_mm_sched_ram_rdata     (ram_rdata),
      .o_lsu_mm_sched_a_alloc_vld   (a_alloc_vld),
      .o_lsu_mm_sched_b_alloc_vld   (b_alloc_vld),
      .o_lsu_mm_sched_alloc_addr    (alloc_addr),
      .o_lsu_mm_sched_alloc_data    (alloc_data),
      .o_lsu_mm_sched_mxu_vld       (mxu_vld),
      .o_lsu_mm_sched_mxu_step      (mxu_step),
      .o_lsu_mm_sched_done          (done),
      .o_lsu_mm_sched_err           (err)
   );

   // RAM model, latency 1: each line holds its own address replicated.
   always @(posedge clk) begin
      if (ram_read_vld) ram_rdata <= {16{ram_read_addr}};
   end

   // Per-command trace captured by run_cmd.
   logic [7:0]   q_rd_addr[$];
   int           q_rd_cyc[$];
   logic [3:0]   q_a_idx[$];
   int           q_a_cyc[$];
   logic [127:0] q_a_data[$];
   logic [3:0]   q_b_idx[$];
   int           q_b_cyc[$];
   logic [127:0] q_b_data[$];
   logic [4:0]   q_step[$];
   int           q_mxu_cyc[$];
   int           done_cyc;
   logic         done_err;
   logic         rdy_busy;
   logic         rdy_after;

   // Issue one command from idle and trace it until done (bounded).
   task automatic run_cmd(input logic [11:0] a, input logic [11:0] b,
                          input logic [3:0] r, input logic [3:0] c, input int max_cyc);
      q_rd_addr.delete(); q_rd_cyc.delete();
      q_a_idx.delete(); q_a_cyc.delete(); q_a_data.delete();
      q_b_idx.delete(); q_b_cyc.delete(); q_b_data.delete();
      q_step.delete(); q_mxu_cyc.delete();
      done_cyc  = -1;
      done_err  = 1'b0;
      rdy_busy  = 1'b0;
      rdy_after = 1'b0;
      @(negedge clk);
      cmd_vld = 1'b1; cmd_a_addr = a; cmd_b_addr = b; cmd_row_len = r; cmd_col_len = c;
      @(posedge clk);
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (i == 1) cmd_vld = 1'b0;
         if (ram_read_vld) begin q_rd_addr.push_back(ram_read_addr); q_rd_cyc.push_back(i); end
         if (a_alloc_vld) begin q_a_idx.push_back(alloc_addr); q_a_cyc.push_back(i); q_a_data.push_back(alloc_data); end
         if (b_alloc_vld) begin q_b_idx.push_back(alloc_addr); q_b_cyc.push_back(i); q_b_data.push_back(alloc_data); end
         if (mxu_vld) begin q_step.push_back(mxu_step); q_mxu_cyc.push_back(i); end
         if (cmd_rdy) rdy_busy = 1'b1;
         if (done) begin
            done_cyc = i;
            done_err = err;
            @(negedge clk);
            rdy_after = cmd_rdy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_vld = 1'b0; ext_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({cmd_rdy, ram_read_vld, a_alloc_vld, b_alloc_vld, mxu_vld, done, err, ext_gnt, ext_rdata_vld} !== 9'b1_0000_0000) $display("FAIL reset_ctrl: got %b want %b", {cmd_rdy, ram_read_vld, a_alloc_vld, b_alloc_vld, mxu_vld, done, err, ext_gnt, ext_rdata_vld}, 9'b1_0000_0000);
      else n_pass++;
      n_total++;
      if ({mxu_step, alloc_addr} !== 9'd0) $display("FAIL reset_idx: got step=%0d addr=%0d want 0/0", mxu_step, alloc_addr);
      else n_pass++;
      n_total++;
      if (alloc_data !== ram_rdata) $display("FAIL reset_data: got %h want %h", alloc_data, ram_rdata);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if ({cmd_rdy, ram_read_vld, mxu_vld, done} !== 4'b1000) $display("FAIL idle_after_reset: got %b want 1000", {cmd_rdy, ram_read_vld, mxu_vld, done});
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [7:0] exp_addr [7];
      exp_addr = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h3F, 8'h40, 8'h41};
      run_cmd(12'h120, 12'h3F0, 4'd4, 4'd3, 40);
      n_total++;
      if (q_rd_addr.size() != 7) $display("FAIL basic_nreads: got %0d want 7", q_rd_addr.size()); else n_pass++;
      for (int k = 0; k < q_rd_addr.size() && k < 7; k++) begin
         n_total++;
         if (q_rd_addr[k] !== exp_addr[k] || q_rd_cyc[k] != k + 1) $display("FAIL basic_read%0d: got addr=%h cyc=%0d want addr=%h cyc=%0d", k, q_rd_addr[k], q_rd_cyc[k], exp_addr[k], k + 1);
         else n_pass++;
      end
      n_total++;
      if (q_a_idx.size() != 4 || q_b_idx.size() != 3) $display("FAIL basic_nalloc: got a=%0d b=%0d want a=4 b=3", q_a_idx.size(), q_b_idx.size()); else n_pass++;
      for (int k = 0; k < q_a_idx.size() && k < 4; k++) begin
         n_total++;
         if (q_a_idx[k] !== 4'(k) || q_a_cyc[k] != k + 2) $display("FAIL basic_a_alloc%0d: got idx=%0d cyc=%0d want idx=%0d cyc=%0d", k, q_a_idx[k], q_a_cyc[k], k, k + 2);
         else n_pass++;
      end
      for (int k = 0; k < q_b_idx.size() && k < 3; k++) begin
         n_total++;
         if (q_b_idx[k] !== 4'(k) || q_b_cyc[k] != k + 6) $display("FAIL basic_b_alloc%0d: got idx=%0d cyc=%0d want idx=%0d cyc=%0d", k, q_b_idx[k], q_b_cyc[k], k, k + 6);
         else n_pass++;
      end
      if (q_a_data.size() > 0) begin
         n_total++;
         if (q_a_data[0] !== {16{8'h12}}) $display("FAIL basic_a_data: got %h want %h", q_a_data[0], {16{8'h12}}); else n_pass++;
      end
      if (q_b_data.size() > 2) begin
         n_total++;
         if (q_b_data[2] !== {16{8'h41}}) $display("FAIL basic_b_data: got %h want %h", q_b_data[2], {16{8'h41}}); else n_pass++;
      end
      n_total++;
      if (q_step.size() != 6) $display("FAIL basic_feed_len: got %0d want 6", q_step.size()); else n_pass++;
      for (int s = 0; s < q_step.size() && s < 6; s++) begin
         n_total++;
         if (q_step[s] !== 5'(s) || q_mxu_cyc[s] != s + 9) $display("FAIL basic_step%0d: got step=%0d cyc=%0d want step=%0d cyc=%0d", s, q_step[s], q_mxu_cyc[s], s, s + 9);
         else n_pass++;
      end
      n_total++;
      if (done_cyc != 15 || done_err !== 1'b0) $display("FAIL basic_done: got cyc=%0d err=%b want cyc=15 err=0", done_cyc, done_err); else n_pass++;
      n_total++;
      if (rdy_after !== 1'b1 || rdy_busy !== 1'b0) $display("FAIL basic_rdy: got after=%b busy=%b want after=1 busy=0", rdy_after, rdy_busy); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [7:0] exp_addr [4];
      exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h55};
      run_cmd(12'hFE0, 12'h550, 4'd3, 4'd1, 40);
      n_total++;
      if (q_rd_addr.size() != 4) $display("FAIL wrap_nreads: got %0d want 4", q_rd_addr.size()); else n_pass++;
      for (int k = 0; k < q_rd_addr.size() && k < 4; k++) begin
         n_total++;
         if (q_rd_addr[k] !== exp_addr[k]) $display("FAIL wrap_read%0d: got %h want %h", k, q_rd_addr[k], exp_addr[k]);
         else n_pass++;
      end
      n_total++;
      if (q_step.size() != 3 || done_cyc != 9) $display("FAIL wrap_feed: got len=%0d done=%0d want len=3 done=9", q_step.size(), done_cyc); else n_pass++;
   endtask

   task automatic test_max();
      run_cmd(12'h000, 12'h100, 4'd15, 4'd15, 100);
      n_total++;
      if (q_rd_addr.size() != 30) $display("FAIL max_nreads: got %0d want 30", q_rd_addr.size()); else n_pass++;
      if (q_rd_addr.size() == 30) begin
         n_total++;
         if (q_rd_addr[14] !== 8'h0E || q_rd_addr[15] !== 8'h10 || q_rd_addr[29] !== 8'h1E) $display("FAIL max_addrs: got %h %h %h want 0e 10 1e", q_rd_addr[14], q_rd_addr[15], q_rd_addr[29]);
         else n_pass++;
      end
      n_total++;
      if (q_a_idx.size() != 15 || q_b_idx.size() != 15) $display("FAIL max_nalloc: got a=%0d b=%0d want 15/15", q_a_idx.size(), q_b_idx.size()); else n_pass++;
      n_total++;
      if (q_step.size() != 29) $display("FAIL max_feed_len: got %0d want 29", q_step.size()); else n_pass++;
      if (q_step.size() == 29) begin
         n_total++;
         if (q_step[28] !== 5'd28 || q_mxu_cyc[0] != 32) $display("FAIL max_step: got last=%0d first_cyc=%0d want 28/32", q_step[28], q_mxu_cyc[0]);
         else n_pass++;
      end
      n_total++;
      if (done_cyc != 61) $display("FAIL max_done: got %0d want 61", done_cyc); else n_pass++;
   endtask

   task automatic test_illegal();
      run_cmd(12'h100, 12'h200, 4'd0, 4'd5, 10);
      n_total++;
      if (q_rd_addr.size() != 0) $display("FAIL illegal_r0_reads: got %0d want 0", q_rd_addr.size()); else n_pass++;
      n_total++;
      if (done_cyc != 1 || done_err !== 1'b1 || rdy_after !== 1'b1) $display("FAIL illegal_r0_done: got cyc=%0d err=%b rdy=%b want 1/1/1", done_cyc, done_err, rdy_after); else n_pass++;
      run_cmd(12'h100, 12'h200, 4'd2, 4'd0, 10);
      n_total++;
      if (q_rd_addr.size() != 0 || done_cyc != 1 || done_err !== 1'b1) $display("FAIL illegal_c0: got reads=%0d cyc=%0d err=%b want 0/1/1", q_rd_addr.size(), done_cyc, done_err); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] got_addr[$];
      int         got_cyc[$];
      int         got_done[$];
      logic [7:0] exp_addr [4];
      int         exp_cyc [4];
      exp_addr = '{8'h05, 8'h06, 8'h05, 8'h06};
      exp_cyc  = '{1, 2, 7, 8};
      @(negedge clk);
      cmd_vld = 1'b1; cmd_a_addr = 12'h050; cmd_b_addr = 12'h060; cmd_row_len = 4'd1; cmd_col_len = 4'd1;
      @(posedge clk);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (ram_read_vld) begin got_addr.push_back(ram_read_addr); got_cyc.push_back(i); end
         if (done) got_done.push_back(i);
      end
      cmd_vld = 1'b0;
      n_total++;
      if (got_addr.size() != 4) $display("FAIL b2b_nreads: got %0d want 4", got_addr.size()); else n_pass++;
      for (int k = 0; k < got_addr.size() && k < 4; k++) begin
         n_total++;
         if (got_addr[k] !== exp_addr[k] || got_cyc[k] != exp_cyc[k]) $display("FAIL b2b_read%0d: got addr=%h cyc=%0d want addr=%h cyc=%0d", k, got_addr[k], got_cyc[k], exp_addr[k], exp_cyc[k]);
         else n_pass++;
      end
      n_total++;
      if (got_done.size() != 2) $display("FAIL b2b_ndone: got %0d want 2", got_done.size());
      else if (got_done[0] != 5 || got_done[1] != 11) $display("FAIL b2b_done: got %0d,%0d want 5,11", got_done[0], got_done[1]);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_contention();
      // bit i = expected value in cycle T+i
      logic [10:0] exp_gnt;
      logic [10:0] exp_rvld;
      logic [10:0] exp_alloc;
      logic [10:0] exp_done;
      logic [7:0]  exp_ra [1:10];
      exp_gnt   = 11'b11111100000;
      exp_rvld  = 11'b11111000010;
      exp_alloc = 11'b00000111100;
      exp_done  = 11'b01000000000;
      exp_ra    = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      @(negedge clk);
      cmd_vld = 1'b1; cmd_a_addr = 12'h200; cmd_b_addr = 12'h300; cmd_row_len = 4'd2; cmd_col_len = 4'd2;
      ext_req = 1'b1; ext_addr = 8'h80;
      @(posedge clk);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) cmd_vld = 1'b0;
         n_total++;
         if ({ext_gnt, ext_rdata_vld, a_alloc_vld | b_alloc_vld, done, ram_read_vld} !== {exp_gnt[i], exp_rvld[i], exp_alloc[i], exp_done[i], 1'b1} || ram_read_addr !== exp_ra[i])
            $display("FAIL contend_cyc%0d: got gnt/rvld/alloc/done/rd=%b addr=%h want %b addr=%h", i, {ext_gnt, ext_rdata_vld, a_alloc_vld | b_alloc_vld, done, ram_read_vld}, ram_read_addr, {exp_gnt[i], exp_rvld[i], exp_alloc[i], exp_done[i], 1'b1}, exp_ra[i]);
         else n_pass++;
      end
      ext_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_feed();
      logic seen_done;
      @(negedge clk);
      cmd_vld = 1'b1; cmd_a_addr = 12'h010; cmd_b_addr = 12'h020; cmd_row_len = 4'd3; cmd_col_len = 4'd2;
      @(posedge clk);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 1) cmd_vld = 1'b0;
      end
      n_total++;
      if ({mxu_vld, mxu_step} !== {1'b1, 5'd2}) $display("FAIL midfeed_step: got vld=%b step=%0d want 1/2", mxu_vld, mxu_step); else n_pass++;
      rst_n = 1'b0;
      @(negedge clk);
      n_total++;
      if ({cmd_rdy, mxu_vld, done, ram_read_vld} !== 4'b1000 || mxu_step !== 5'd0) $display("FAIL midfeed_reset: got rdy/vld/done/rd=%b step=%0d want 1000/0", {cmd_rdy, mxu_vld, done, ram_read_vld}, mxu_step); else n_pass++;
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      n_total++;
      if (seen_done !== 1'b0) $display("FAIL midfeed_no_done: got done=%b want 0", seen_done); else n_pass++;
      run_cmd(12'h070, 12'h080, 4'd1, 4'd1, 20);
      n_total++;
      if (done_cyc != 5 || done_err !== 1'b0 || q_rd_addr.size() != 2) $display("FAIL midfeed_recover: got done=%0d err=%b reads=%0d want 5/0/2", done_cyc, done_err, q_rd_addr.size());
      else if (q_rd_addr[0] !== 8'h07 || q_rd_addr[1] !== 8'h08) $display("FAIL midfeed_recover: got addrs %h %h want 07 08", q_rd_addr[0], q_rd_addr[1]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_max();
      test_illegal();
      test_back_to_back();
      test_contention();
      test_reset_mid_feed();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
